simon_share_ctrl: RTL and testbench

SIMON_SHARE_CTRL -- requirements
Module: simon_share_ctrl

---
 rtl/simon_pkg.sv | 22 ++
 rtl/simon_rr_arb.sv | 35 +++
 rtl/simon_share_ctrl.sv | 179 +++++++++++++++++
 tb/tb_simon_share_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon 32/64 core-sharing controller.
// Holds the FSM state encoding, the key/block widths and the requester id type.
package simon_pkg;

   localparam int KEY_W = 64;
   localparam int BLK_W = 32;
   localparam int N_REQ = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   typedef logic req_id_t;

   function automatic logic [N_REQ-1:0] id_onehot(input req_id_t id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/simon_rr_arb.sv
// Two-way round-robin arbiter; ptr names the requester that wins a tie.
// The grant is combinational; the pointer moves only when a grant is taken.
module simon_rr_arb
   import simon_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   input  logic             take,
   output logic [N_REQ-1:0] gnt,
   output req_id_t          gnt_id
);

   req_id_t ptr;

   always_comb begin
      gnt_id = ptr;
      if (req[0] && !req[1]) begin
         gnt_id = 1'b0;
      end else if (req[1] && !req[0]) begin
         gnt_id = 1'b1;
      end
      gnt = (req != '0) ? id_onehot(gnt_id) : '0;
   end

   // After a grant the other requester gets priority on the next tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr <= 1'b0;
      end else if (take && (req != '0)) begin
         ptr <= ~gnt_id;
      end
   end

endmodule

// File: rtl/simon_share_ctrl.sv
// Shares one Simon 32/64 core between two requesters (IDLE/START/WAIT/RESP).
// Defining SIMON_SHARE_TIMEOUT_EN adds a WAIT watchdog and the rspN_err flags.
//
// Handshakes: a request transfers on the cycle reqN_valid && reqN_ready; a
// response transfers on the cycle rspN_valid && rspN_ready. rspN_valid and
// rspN_ct hold until that transfer; ready without valid has no effect.
module simon_share_ctrl
   import simon_pkg::*;
#(
   parameter int START_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 255
)
(
   input  logic             clk,
   input  logic             reset,

   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [KEY_W-1:0] req0_key,
   input  logic [BLK_W-1:0] req0_pt,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [KEY_W-1:0] req1_key,
   input  logic [BLK_W-1:0] req1_pt,

   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [BLK_W-1:0] rsp0_ct,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [BLK_W-1:0] rsp1_ct,
`ifdef SIMON_SHARE_TIMEOUT_EN
   output logic             rsp0_err,
   output logic             rsp1_err,
`endif

   output logic             core_start,
   output logic [KEY_W-1:0] core_key,
   output logic [BLK_W-1:0] core_pt,
   input  logic [BLK_W-1:0] core_ct,
   input  logic             core_done,

   output logic             busy,
   output state_t           state
);

   localparam int SW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
   localparam logic [SW-1:0] START_LAST = SW'(START_CYCLES - 1);

`ifdef SIMON_SHARE_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0]    wait_cnt;
   logic [N_REQ-1:0] rsp_err_q;
`endif

   logic [N_REQ-1:0]            req_valid;
   logic [N_REQ-1:0]            rsp_ready;
   logic [N_REQ-1:0]            gnt;
   logic [N_REQ-1:0]            rsp_valid_q;
   logic [N_REQ-1:0][BLK_W-1:0] rsp_ct_q;
   logic [SW-1:0]               start_cnt;
   logic                        grant_ok;
   req_id_t                     gnt_id;
   req_id_t                     job_id;

   assign req_valid = {req1_valid, req0_valid};
   assign rsp_ready = {rsp1_ready, rsp0_ready};

   // Reset is folded in so ready stays low while reset is held.
   assign grant_ok = (state == ST_IDLE) && !reset;

   simon_rr_arb u_arb (
      .clk    (clk),
      .reset  (reset),
      .req    (req_valid),
      .take   (grant_ok),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   assign req0_ready = grant_ok && gnt[0];
   assign req1_ready = grant_ok && gnt[1];

   assign rsp0_valid = rsp_valid_q[0];
   assign rsp1_valid = rsp_valid_q[1];
   assign rsp0_ct    = rsp_ct_q[0];
   assign rsp1_ct    = rsp_ct_q[1];
`ifdef SIMON_SHARE_TIMEOUT_EN
   assign rsp0_err   = rsp_err_q[0];
   assign rsp1_err   = rsp_err_q[1];
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         job_id      <= 1'b0;
         start_cnt   <= '0;
         core_start  <= 1'b0;
         core_key    <= '0;
         core_pt     <= '0;
         rsp_valid_q <= '0;
         rsp_ct_q    <= '0;
         busy        <= 1'b0;
`ifdef SIMON_SHARE_TIMEOUT_EN
         wait_cnt    <= '0;
         rsp_err_q   <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid != '0) begin
                  state      <= ST_START;
                  job_id     <= gnt_id;
                  core_key   <= gnt_id ? req1_key : req0_key;
                  core_pt    <= gnt_id ? req1_pt  : req0_pt;
                  core_start <= 1'b1;
                  start_cnt  <= '0;
                  busy       <= 1'b1;
               end
            end

            // core_done is deliberately not looked at while the strobe is up.
            ST_START: begin
               if (start_cnt == START_LAST) begin
                  state      <= ST_WAIT;
                  core_start <= 1'b0;
`ifdef SIMON_SHARE_TIMEOUT_EN
                  wait_cnt   <= '0;
`endif
               end else begin
                  start_cnt <= start_cnt + 1'b1;
               end
            end

            ST_WAIT: begin
               if (core_done) begin
                  state            <= ST_RESP;
                  rsp_valid_q      <= id_onehot(job_id);
                  rsp_ct_q[job_id] <= core_ct;
                  core_key         <= '0;
                  core_pt          <= '0;
`ifdef SIMON_SHARE_TIMEOUT_EN
                  rsp_err_q        <= '0;
               end else if (wait_cnt == TIMEOUT_LAST) begin
                  state            <= ST_RESP;
                  rsp_valid_q      <= id_onehot(job_id);
                  rsp_ct_q[job_id] <= '0;
                  rsp_err_q        <= id_onehot(job_id);
                  core_key         <= '0;
                  core_pt          <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
`endif
               end
            end

            // Only the owning requester's ready can retire the response.
            ST_RESP: begin
               if (rsp_ready[job_id] && rsp_valid_q[job_id]) begin
                  state       <= ST_IDLE;
                  rsp_valid_q <= '0;
                  rsp_ct_q    <= '0;
                  busy        <= 1'b0;
`ifdef SIMON_SHARE_TIMEOUT_EN
                  rsp_err_q   <= '0;
`endif
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_simon_share_ctrl.sv
// Directed bench for simon_share_ctrl with a behavioural Simon 32/64 core.
// Covers SIMON_SHARE_TIMEOUT_EN when that macro is defined for the build.
module tb_simon_share_ctrl;
   import simon_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [63:0] req0_key, req1_key;
   logic [31:0] req0_pt, req1_pt;
   logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [31:0] rsp0_ct, rsp1_ct;
`ifdef SIMON_SHARE_TIMEOUT_EN
   logic        rsp0_err, rsp1_err;
`endif
   logic        core_start, core_done, busy;
   logic [63:0] core_key;
   logic [31:0] core_pt, core_ct;
   state_t      dut_state;

   int vectors = 0;
   int miscompares = 0;

   simon_share_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_key   (req0_key),
      .req0_pt    (req0_pt),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_key   (req1_key),
      .req1_pt    (req1_pt),
      .rsp0_valid (rsp0_valid),
      .rsp0_ready (rsp0_ready),
      .rsp0_ct    (rsp0_ct),
      .rsp1_valid (rsp1_valid),
      .rsp1_ready (rsp1_ready),
      .rsp1_ct    (rsp1_ct),
`ifdef SIMON_SHARE_TIMEOUT_EN
      .rsp0_err   (rsp0_err),
      .rsp1_err   (rsp1_err),
`endif
      .core_start (core_start),
      .core_key   (core_key),
      .core_pt    (core_pt),
      .core_ct    (core_ct),
      .core_done  (core_done),
      .busy       (busy),
      .state      (dut_state)
   );

   // ---------------- behavioural Simon 32/64 core ----------------
   function automatic logic [15:0] rol16(input logic [15:0] v, input int n);
      return (v << n) | (v >> (16 - n));
   endfunction

   function automatic logic [31:0] simon_enc(input logic [63:0] key, input logic [31:0] pt);
      logic [15:0] k [32];
      logic [15:0] x, y, tmp;
      logic [61:0] z;
      z = 62'b01100111000011010100100010111110110011100001101010010001011111;
      k[0] = key[15:0];
      k[1] = key[31:16];
      k[2] = key[47:32];
      k[3] = key[63:48];
      for (int i = 4; i < 32; i++) begin
         tmp  = rol16(k[i-1], 13) ^ k[i-3];
         tmp  = tmp ^ rol16(tmp, 15);
         k[i] = ~k[i-4] ^ tmp ^ {15'b0, z[i-4]} ^ 16'd3;
      end
      x = pt[31:16];
      y = pt[15:0];
      for (int i = 0; i < 32; i++) begin
         tmp = x;
         x   = y ^ (rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2) ^ k[i];
         y   = tmp;
      end
      return {x, y};
   endfunction

   logic       core_mute = 1'b0;
   logic       start_d;
   logic [2:0] core_cnt;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         start_d   <= 1'b0;
         core_cnt  <= '0;
         core_done <= 1'b0;
         core_ct   <= '0;
      end else begin
         start_d   <= core_start;
         core_done <= 1'b0;
         if (core_start && !start_d) begin
            core_ct  <= simon_enc(core_key, core_pt);
            core_cnt <= 3'd5;
         end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1'b1;
            if (core_cnt == 3'd1 && !core_mute) core_done <= 1'b1;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_rsp(input string tag);
      int n;
      n = 0;
      while (!(rsp0_valid || rsp1_valid) && n < 100) begin
         tick();
         n++;
      end
      chk({tag, "_rsp_arrives"}, 64'(rsp0_valid || rsp1_valid), 64'd1);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"},  64'(busy), 64'd0);
      chk({tag, "_state"}, 64'(dut_state), 64'(ST_IDLE));
      chk({tag, "_start"}, 64'(core_start), 64'd0);
      chk({tag, "_key"},   core_key, 64'd0);
      chk({tag, "_pt"},    64'(core_pt), 64'd0);
      chk({tag, "_rspv"},  64'({rsp1_valid, rsp0_valid}), 64'd0);
      chk({tag, "_ct"},    {rsp1_ct, rsp0_ct}, 64'd0);
      chk({tag, "_rdy"},   64'({req1_ready, req0_ready}), 64'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      reset = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_key = '0; req1_key = '0; req0_pt = '0; req1_pt = '0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      tick();
      tick();
      check_all_zero("reset");
      reset = 1'b0;
      tick();

      // Single job on requester 0
      req0_valid = 1'b1; req0_key = 64'h1918111009080100; req0_pt = 32'h65656877;
      #1;
      chk("single_rdy0", 64'(req0_ready), 64'd1);
      chk("single_rdy1", 64'(req1_ready), 64'd0);
      tick();
      req0_valid = 1'b0;
      chk("single_key", core_key, 64'h1918111009080100);
      chk("single_pt",  64'(core_pt), 64'h65656877);
      chk("single_busy", 64'(busy), 64'd1);
      n = 0;
      while (core_start && n < 10) begin
         tick();
         n++;
      end
      chk("single_start_len", 64'(n), 64'd2);
      chk("single_wait_state", 64'(dut_state), 64'(ST_WAIT));
      chk("single_key_held", core_key, 64'h1918111009080100);
      wait_rsp("single");
      chk("single_rsp0v", 64'(rsp0_valid), 64'd1);
      chk("single_rsp1v", 64'(rsp1_valid), 64'd0);
      chk("single_ct", 64'(rsp0_ct), 64'hc69be9bb);
      rsp0_ready = 1'b1;
      tick();
      rsp0_ready = 1'b0;
      chk("single_done_v", 64'(rsp0_valid), 64'd0);
      chk("single_idle", 64'(dut_state), 64'(ST_IDLE));

      // Contention right after reset: requester 0 wins, requester 1 waits
      reset = 1'b1;
      tick();
      reset = 1'b0;
      req0_valid = 1'b1; req0_key = 64'hae4f4b3f2bea21bb; req0_pt = 32'hb94dd41b;
      req1_valid = 1'b1; req1_key = 64'h09586108cdaade2c; req1_pt = 32'h9d09da8b;
      #1;
      chk("cont_rdy0", 64'(req0_ready), 64'd1);
      chk("cont_rdy1", 64'(req1_ready), 64'd0);
      tick();
      req0_valid = 1'b0;
      chk("cont_busy_rdy1", 64'(req1_ready), 64'd0);
      wait_rsp("cont_a");
      chk("cont_a_rsp1v", 64'(rsp1_valid), 64'd0);
      chk("cont_a_ct", 64'(rsp0_ct), 64'h8494f458);
      chk("cont_a_rdy1", 64'(req1_ready), 64'd0);
      rsp0_ready = 1'b1;
      tick();
      rsp0_ready = 1'b0;
      chk("cont_b_rdy1", 64'(req1_ready), 64'd1);
      tick();
      req1_valid = 1'b0;
      wait_rsp("cont_b");
      chk("cont_b_rsp0v", 64'(rsp0_valid), 64'd0);
      chk("cont_b_ct", 64'(rsp1_ct), 64'hdeb4c76b);
      rsp1_ready = 1'b1;
      tick();
      rsp1_ready = 1'b0;

      // Fairness: both held valid, both rsp_ready held high throughout
      req0_valid = 1'b1; req1_valid = 1'b1;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         #1;
         chk("fair_rdy0", 64'(req0_ready), 64'(j % 2 == 0));
         chk("fair_rdy1", 64'(req1_ready), 64'(j % 2 == 1));
         tick();
         chk("fair_started", 64'(dut_state), 64'(ST_START));
         wait_rsp("fair");
         chk("fair_rsp0v", 64'(rsp0_valid), 64'(j % 2 == 0));
         chk("fair_rsp1v", 64'(rsp1_valid), 64'(j % 2 == 1));
         chk("fair_ct", 64'(rsp0_ct | rsp1_ct), (j % 2 == 0) ? 64'h8494f458 : 64'hdeb4c76b);
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;

      // Backpressure on requester 1 while requester 0 waits
      req1_valid = 1'b1; req1_key = 64'ha1f6a78d5886c60a; req1_pt = 32'h5be7b347;
      #1;
      chk("bp_rdy1", 64'(req1_ready), 64'd1);
      tick();
      req1_valid = 1'b0;
      wait_rsp("bp");
      req0_valid = 1'b1; req0_key = 64'h1918111009080100; req0_pt = 32'h65656877;
      for (int j = 0; j < 20; j++) begin
         chk("bp_hold_v", 64'(rsp1_valid), 64'd1);
         chk("bp_hold_ct", 64'(rsp1_ct), 64'hfc29a459);
         chk("bp_hold_rdy0", 64'(req0_ready), 64'd0);
         tick();
      end
      rsp1_ready = 1'b1;
      tick();
      rsp1_ready = 1'b0;
      chk("bp_released_v", 64'(rsp1_valid), 64'd0);
      chk("bp_rdy0_now", 64'(req0_ready), 64'd1);
      tick();
      req0_valid = 1'b0;
      wait_rsp("bp_req0");
      chk("bp_req0_ct", 64'(rsp0_ct), 64'hc69be9bb);
      rsp0_ready = 1'b1;
      tick();
      rsp0_ready = 1'b0;

      // Reset while in WAIT, then a fresh job granted right after release
      req0_valid = 1'b1; req0_key = 64'ha1f6a78d5886c60a; req0_pt = 32'h5be7b347;
      tick();
      req0_valid = 1'b0;
      tick();
      tick();
      chk("rst_in_wait", 64'(dut_state), 64'(ST_WAIT));
      reset = 1'b1;
      req0_valid = 1'b1; req0_key = 64'hccc85d3d82b2d23a; req0_pt = 32'he8e18044;
      #1;
      check_all_zero("rst_async");
      tick();
      check_all_zero("rst_held");
      reset = 1'b0;
      #1;
      chk("rst_first_grant", 64'(req0_ready), 64'd1);
      tick();
      req0_valid = 1'b0;
      wait_rsp("rst_fresh");
      chk("rst_fresh_rsp1v", 64'(rsp1_valid), 64'd0);
      chk("rst_fresh_ct", 64'(rsp0_ct), 64'h32294659);
      rsp0_ready = 1'b1;
      tick();
      rsp0_ready = 1'b0;

`ifdef SIMON_SHARE_TIMEOUT_EN
      // Silent core: the watchdog must answer with err set and ct zero
      core_mute = 1'b1;
      req1_valid = 1'b1; req1_key = 64'h1918111009080100; req1_pt = 32'h65656877;
      tick();
      req1_valid = 1'b0;
      tick();
      tick();
      chk("to_wait", 64'(dut_state), 64'(ST_WAIT));
      n = 0;
      while (!rsp1_valid && n < 400) begin
         tick();
         n++;
      end
      chk("to_cycles", 64'(n), 64'd255);
      chk("to_v", 64'(rsp1_valid), 64'd1);
      chk("to_err", 64'(rsp1_err), 64'd1);
      chk("to_ct", 64'(rsp1_ct), 64'd0);
      rsp1_ready = 1'b1;
      tick();
      rsp1_ready = 1'b0;
      core_mute = 1'b0;
      req0_valid = 1'b1;
      tick();
      req0_valid = 1'b0;
      wait_rsp("to_normal");
      chk("to_normal_err", 64'(rsp0_err), 64'd0);
      chk("to_normal_ct", 64'(rsp0_ct), 64'h32294659);
      rsp0_ready = 1'b1;
      tick();
      rsp0_ready = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
